// File: rtl/vga_pkg.sv
// Shared video-output definitions: channel widths, the 2x2 Bayer offsets and
// the stage-1 pipeline record used by the dither stage.
package vga_pkg;

  localparam int COLOR_W  = 6;
  localparam int DAC_W    = 3;
  localparam int OFFSET_W = 3;

  // Indexed by {row_par, col_par}: 00->0, 01->4, 10->6, 11->2.
  localparam logic [3:0][OFFSET_W-1:0] BAYER_OFFSETS = {3'd2, 3'd6, 3'd4, 3'd0};

  typedef struct packed {
    logic [COLOR_W-1:0]  r;
    logic [COLOR_W-1:0]  g;
    logic [COLOR_W-1:0]  b;
    logic                blank;
    logic                hsync;
    logic                vsync;
    logic [OFFSET_W-1:0] offset;
  } stage1_t;

  function automatic logic [OFFSET_W-1:0] bayer_offset(input logic [1:0] idx);
    return BAYER_OFFSETS[idx];
  endfunction

endpackage

// File: rtl/dither_channel.sv
// One colour channel: add the Bayer offset, saturate at full scale, keep the
// top DAC bits. Purely combinational.
module dither_channel
  import vga_pkg::*;
(
  input  logic [COLOR_W-1:0]  value,
  input  logic [OFFSET_W-1:0] offset,
  output logic [DAC_W-1:0]    result
);

  logic [COLOR_W:0]   sum;
  logic [COLOR_W-1:0] sat;

  assign sum    = {1'b0, value} + {{(COLOR_W + 1 - OFFSET_W){1'b0}}, offset};
  // The carry bit alone marks an overflow past 63, so clamp instead of wrapping.
  assign sat    = sum[COLOR_W] ? {COLOR_W{1'b1}} : sum[COLOR_W-1:0];
  assign result = sat[COLOR_W-1 -: DAC_W];

endmodule

// File: rtl/vga_dither.sv
// Ordered-dither output stage: 6-bit RGB to 3-bit DAC pins with a 2x2 Bayer
// matrix, raster parity recovered from the forwarded sync signals.
module vga_dither
  import vga_pkg::*;
#(
  parameter bit SYNC_ACTIVE_LOW = 1'b1,
  parameter bit TEMPORAL        = 1'b1
) (
  input  logic               clk_vga,
  input  logic               rst,
  input  logic               pix_ce,
  input  logic [COLOR_W-1:0] r_in,
  input  logic [COLOR_W-1:0] g_in,
  input  logic [COLOR_W-1:0] b_in,
  input  logic               blank_in,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic               dither_en,
  output logic [DAC_W-1:0]   vga_r,
  output logic [DAC_W-1:0]   vga_g,
  output logic [DAC_W-1:0]   vga_b,
  output logic               vga_hsync,
  output logic               vga_vsync
);

  localparam logic SYNC_IDLE   = SYNC_ACTIVE_LOW;
  localparam logic SYNC_ACTIVE = ~SYNC_ACTIVE_LOW;

  logic                hs_prev;
  logic                vs_prev;
  logic                col_par;
  logic                row_par;
  logic                frame_par;
  logic                hs_lead;
  logic                vs_lead;
  logic [1:0]          bayer_idx;
  logic [OFFSET_W-1:0] offset_sel;
  stage1_t             s1;
  logic [DAC_W-1:0]    dith_r;
  logic [DAC_W-1:0]    dith_g;
  logic [DAC_W-1:0]    dith_b;

  assign hs_lead = (hsync_in == SYNC_ACTIVE) && (hs_prev != SYNC_ACTIVE);
  assign vs_lead = (vsync_in == SYNC_ACTIVE) && (vs_prev != SYNC_ACTIVE);

  // Offset comes from the parities as they stand before this sample updates them.
  assign bayer_idx  = {row_par, col_par ^ (TEMPORAL & frame_par)};
  assign offset_sel = dither_en ? bayer_offset(bayer_idx) : '0;

  // Raster tracking: edge detect and parity counters.
  // NOTE: reset is synchronous and checked before pix_ce so it wins mid-line;
  // all state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk_vga) begin
    if (rst) begin
      hs_prev   <= SYNC_IDLE;
      vs_prev   <= SYNC_IDLE;
      col_par   <= 1'b0;
      row_par   <= 1'b0;
      frame_par <= 1'b0;
    end else if (pix_ce) begin
      hs_prev <= hsync_in;
      vs_prev <= vsync_in;

      if (hs_lead)        col_par <= 1'b0;
      else if (!blank_in) col_par <= ~col_par;

      // A frame start re-homes the row even if a line start lands on the same strobe.
      if (vs_lead)      row_par <= 1'b0;
      else if (hs_lead) row_par <= ~row_par;

      if (TEMPORAL && vs_lead) frame_par <= ~frame_par;
    end
  end

  // Two-stage pixel pipeline; sync rides alongside so it stays aligned with colour.
  always_ff @(posedge clk_vga) begin
    if (rst) begin
      s1        <= '{r: '0, g: '0, b: '0, blank: 1'b1,
                     hsync: SYNC_IDLE, vsync: SYNC_IDLE, offset: '0};
      vga_r     <= '0;
      vga_g     <= '0;
      vga_b     <= '0;
      vga_hsync <= SYNC_IDLE;
      vga_vsync <= SYNC_IDLE;
    end else if (pix_ce) begin
      s1 <= '{r: r_in, g: g_in, b: b_in, blank: blank_in,
              hsync: hsync_in, vsync: vsync_in, offset: offset_sel};

      vga_r     <= s1.blank ? '0 : dith_r;
      vga_g     <= s1.blank ? '0 : dith_g;
      vga_b     <= s1.blank ? '0 : dith_b;
      vga_hsync <= s1.hsync;
      vga_vsync <= s1.vsync;
    end
  end

  dither_channel u_dither_r (.value(s1.r), .offset(s1.offset), .result(dith_r));
  dither_channel u_dither_g (.value(s1.g), .offset(s1.offset), .result(dith_g));
  dither_channel u_dither_b (.value(s1.b), .offset(s1.offset), .result(dith_b));

endmodule

// File: tb/tb_vga_dither.sv
// Directed bench for vga_dither: a TEMPORAL=1 and a TEMPORAL=0 instance share
// every input; expected DAC codes are worked out by hand per scenario.
module tb_vga_dither;

  logic       clk_vga = 1'b0;
  logic       rst;
  logic       pix_ce;
  logic [5:0] r_in, g_in, b_in;
  logic       blank_in, hsync_in, vsync_in, dither_en;
  logic [2:0] vga_r, vga_g, vga_b, st_r, st_g, st_b;
  logic       vga_hsync, vga_vsync, st_hsync, st_vsync;
  logic [10:0] obs0, obs1;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk_vga = ~clk_vga;

  vga_dither #(.SYNC_ACTIVE_LOW(1'b1), .TEMPORAL(1'b1)) u_dut (
    .clk_vga(clk_vga), .rst(rst), .pix_ce(pix_ce),
    .r_in(r_in), .g_in(g_in), .b_in(b_in), .blank_in(blank_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .dither_en(dither_en),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync)
  );

  vga_dither #(.SYNC_ACTIVE_LOW(1'b1), .TEMPORAL(1'b0)) u_dut_static (
    .clk_vga(clk_vga), .rst(rst), .pix_ce(pix_ce),
    .r_in(r_in), .g_in(g_in), .b_in(b_in), .blank_in(blank_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .dither_en(dither_en),
    .vga_r(st_r), .vga_g(st_g), .vga_b(st_b),
    .vga_hsync(st_hsync), .vga_vsync(st_vsync)
  );

  assign obs0 = {vga_r, vga_g, vga_b, vga_hsync, vga_vsync};
  assign obs1 = {st_r, st_g, st_b, st_hsync, st_vsync};

  // One table row: stimulus for one strobe, then the outputs expected right after it.
  typedef struct packed {
    logic [5:0] v;
    logic       bl, hs, vs, den, rs;
    logic [2:0] e0, e1;
    logic       ehs, evs;
  } vec_t;

  function automatic vec_t pv(input logic [5:0] v, input logic bl, hs, vs, den, rs,
                              input logic [2:0] e0, e1, input logic ehs, evs);
    return '{v: v, bl: bl, hs: hs, vs: vs, den: den, rs: rs,
             e0: e0, e1: e1, ehs: ehs, evs: evs};
  endfunction

  task automatic step(input logic [5:0] r, g, b, input logic bl, hs, vs, den, rs);
    @(negedge clk_vga);
    r_in = r; g_in = g; b_in = b;
    blank_in = bl; hsync_in = hs; vsync_in = vs; dither_en = den;
    rst = rs; pix_ce = 1'b1;
    @(posedge clk_vga);
    #1;
    pix_ce = 1'b0; rst = 1'b0;
  endtask

  task automatic do_reset();
    step(6'h00, 6'h00, 6'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    step(6'h3F, 6'h3F, 6'h3F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(6'h3F, 6'h3F, 6'h3F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if ({obs0, obs1} !== {2{3'd7, 3'd7, 3'd7, 1'b0, 1'b0}}) begin
      miscompares++;
      $display("FAIL reset_pre: got %h/%h want %h", obs0, obs1, {3'd7, 3'd7, 3'd7, 1'b0, 1'b0});
    end
    step(6'h3F, 6'h3F, 6'h3F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    vectors++;
    if ({obs0, obs1} !== {2{3'd0, 3'd0, 3'd0, 1'b1, 1'b1}}) begin
      miscompares++;
      $display("FAIL reset_state: got %h/%h want %h", obs0, obs1, {3'd0, 3'd0, 3'd0, 1'b1, 1'b1});
    end
  endtask

  task automatic test_truncation();
    do_reset();
    step(6'h2F, 6'h10, 6'h3F, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    vectors++;
    if ({obs0, obs1} !== {2{3'd0, 3'd0, 3'd0, 1'b1, 1'b1}}) begin
      miscompares++;
      $display("FAIL trunc_lat1: got %h/%h want %h", obs0, obs1, {3'd0, 3'd0, 3'd0, 1'b1, 1'b1});
    end
    step(6'h00, 6'h00, 6'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    vectors++;
    if ({obs0, obs1} !== {2{3'd5, 3'd2, 3'd7, 1'b1, 1'b1}}) begin
      miscompares++;
      $display("FAIL trunc_lat2: got %h/%h want %h", obs0, obs1, {3'd5, 3'd2, 3'd7, 1'b1, 1'b1});
    end
    // Inputs wiggle with pix_ce low: nothing may move.
    @(negedge clk_vga);
    r_in = 6'h3F; g_in = 6'h3F; b_in = 6'h00; hsync_in = 1'b1; vsync_in = 1'b0;
    repeat (3) @(posedge clk_vga);
    #1;
    vectors++;
    if ({obs0, obs1} !== {2{3'd5, 3'd2, 3'd7, 1'b1, 1'b1}}) begin
      miscompares++;
      $display("FAIL trunc_hold: got %h/%h want %h", obs0, obs1, {3'd5, 3'd2, 3'd7, 1'b1, 1'b1});
    end
    step(6'h00, 6'h00, 6'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    vectors++;
    if ({obs0, obs1} !== {2{3'd0, 3'd0, 3'd0, 1'b0, 1'b1}}) begin
      miscompares++;
      $display("FAIL trunc_sync_align: got %h/%h want %h", obs0, obs1, {3'd0, 3'd0, 3'd0, 1'b0, 1'b1});
    end
  endtask

  task automatic test_saturation();
    do_reset();
    step(6'h00, 6'h00, 6'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step(6'h00, 6'h00, 6'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    // Now at row 1: column 0 uses offset 6, column 1 offset 2.
    step(6'h3F, 6'h3A, 6'h31, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step(6'h3F, 6'h3E, 6'h2D, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    vectors++;
    if ({obs0, obs1} !== {2{3'd7, 3'd7, 3'd6, 1'b1, 1'b1}}) begin
      miscompares++;
      $display("FAIL sat_off6: got %h/%h want %h", obs0, obs1, {3'd7, 3'd7, 3'd6, 1'b1, 1'b1});
    end
    step(6'h00, 6'h00, 6'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    vectors++;
    if ({obs0, obs1} !== {2{3'd7, 3'd7, 3'd5, 1'b1, 1'b1}}) begin
      miscompares++;
      $display("FAIL sat_off2: got %h/%h want %h", obs0, obs1, {3'd7, 3'd7, 3'd5, 1'b1, 1'b1});
    end
  endtask

  task automatic test_spatial();
    vec_t t [7];
    t = '{pv(6'h05, 0, 1, 1, 1, 0, 3'd0, 3'd0, 1, 1),
          pv(6'h05, 0, 1, 1, 1, 0, 3'd0, 3'd0, 1, 1),
          pv(6'h00, 1, 0, 1, 1, 0, 3'd1, 3'd1, 1, 1),
          pv(6'h00, 1, 1, 1, 1, 0, 3'd0, 3'd0, 0, 1),
          pv(6'h05, 0, 1, 1, 1, 0, 3'd0, 3'd0, 1, 1),
          pv(6'h05, 0, 1, 1, 1, 0, 3'd1, 3'd1, 1, 1),
          pv(6'h00, 1, 1, 1, 1, 0, 3'd0, 3'd0, 1, 1)};
    do_reset();
    foreach (t[i]) begin
      step(t[i].v, t[i].v, t[i].v, t[i].bl, t[i].hs, t[i].vs, t[i].den, t[i].rs);
      vectors++;
      if ({obs0, obs1} !== {t[i].e0, t[i].e0, t[i].e0, t[i].ehs, t[i].evs,
                            t[i].e1, t[i].e1, t[i].e1, t[i].ehs, t[i].evs}) begin
        miscompares++;
        $display("FAIL spatial[%0d]: got %h/%h want c%0d/c%0d hs%0b vs%0b",
                 i, obs0, obs1, t[i].e0, t[i].e1, t[i].ehs, t[i].evs);
      end
    end
  endtask

  task automatic test_temporal();
    vec_t t [8];
    t = '{pv(6'h05, 0, 1, 1, 1, 0, 3'd0, 3'd0, 1, 1),
          pv(6'h00, 1, 0, 1, 1, 0, 3'd0, 3'd0, 1, 1),
          pv(6'h00, 1, 1, 1, 1, 0, 3'd0, 3'd0, 0, 1),
          pv(6'h00, 1, 1, 0, 1, 0, 3'd0, 3'd0, 1, 1),
          pv(6'h00, 1, 1, 1, 1, 0, 3'd0, 3'd0, 1, 0),
          pv(6'h05, 0, 1, 1, 1, 0, 3'd0, 3'd0, 1, 1),
          pv(6'h05, 0, 1, 1, 1, 0, 3'd1, 3'd0, 1, 1),
          pv(6'h00, 1, 1, 1, 1, 0, 3'd0, 3'd1, 1, 1)};
    do_reset();
    foreach (t[i]) begin
      step(t[i].v, t[i].v, t[i].v, t[i].bl, t[i].hs, t[i].vs, t[i].den, t[i].rs);
      vectors++;
      if ({obs0, obs1} !== {t[i].e0, t[i].e0, t[i].e0, t[i].ehs, t[i].evs,
                            t[i].e1, t[i].e1, t[i].e1, t[i].ehs, t[i].evs}) begin
        miscompares++;
        $display("FAIL temporal[%0d]: got %h/%h want c%0d/c%0d hs%0b vs%0b",
                 i, obs0, obs1, t[i].e0, t[i].e1, t[i].ehs, t[i].evs);
      end
    end
  endtask

  task automatic test_blank();
    vec_t t [4];
    t = '{pv(6'h3F, 1, 1, 1, 1, 0, 3'd0, 3'd0, 1, 1),
          pv(6'h3F, 1, 1, 1, 1, 0, 3'd0, 3'd0, 1, 1),
          pv(6'h3F, 0, 1, 1, 0, 0, 3'd0, 3'd0, 1, 1),
          pv(6'h00, 1, 1, 1, 0, 0, 3'd7, 3'd7, 1, 1)};
    do_reset();
    foreach (t[i]) begin
      step(t[i].v, t[i].v, t[i].v, t[i].bl, t[i].hs, t[i].vs, t[i].den, t[i].rs);
      vectors++;
      if ({obs0, obs1} !== {t[i].e0, t[i].e0, t[i].e0, t[i].ehs, t[i].evs,
                            t[i].e1, t[i].e1, t[i].e1, t[i].ehs, t[i].evs}) begin
        miscompares++;
        $display("FAIL blank[%0d]: got %h/%h want c%0d/c%0d hs%0b vs%0b",
                 i, obs0, obs1, t[i].e0, t[i].e1, t[i].ehs, t[i].evs);
      end
    end
  endtask

  task automatic test_dither_toggle();
    vec_t t [5];
    t = '{pv(6'h06, 0, 1, 1, 1, 0, 3'd0, 3'd0, 1, 1),
          pv(6'h06, 0, 1, 1, 0, 0, 3'd0, 3'd0, 1, 1),
          pv(6'h06, 0, 1, 1, 1, 0, 3'd0, 3'd0, 1, 1),
          pv(6'h06, 0, 1, 1, 1, 0, 3'd0, 3'd0, 1, 1),
          pv(6'h00, 1, 1, 1, 1, 0, 3'd1, 3'd1, 1, 1)};
    do_reset();
    foreach (t[i]) begin
      step(t[i].v, t[i].v, t[i].v, t[i].bl, t[i].hs, t[i].vs, t[i].den, t[i].rs);
      vectors++;
      if ({obs0, obs1} !== {t[i].e0, t[i].e0, t[i].e0, t[i].ehs, t[i].evs,
                            t[i].e1, t[i].e1, t[i].e1, t[i].ehs, t[i].evs}) begin
        miscompares++;
        $display("FAIL dither_toggle[%0d]: got %h/%h want c%0d/c%0d hs%0b vs%0b",
                 i, obs0, obs1, t[i].e0, t[i].e1, t[i].ehs, t[i].evs);
      end
    end
  endtask

  task automatic test_reset_midline();
    vec_t t [13];
    t = '{pv(6'h00, 1, 0, 1, 1, 0, 3'd0, 3'd0, 1, 1),
          pv(6'h00, 1, 1, 1, 1, 0, 3'd0, 3'd0, 0, 1),
          pv(6'h3F, 0, 1, 1, 1, 0, 3'd0, 3'd0, 1, 1),
          pv(6'h3F, 0, 1, 1, 1, 0, 3'd7, 3'd7, 1, 1),
          pv(6'h3F, 0, 1, 1, 1, 0, 3'd7, 3'd7, 1, 1),
          pv(6'h3F, 0, 0, 0, 1, 1, 3'd0, 3'd0, 1, 1),
          pv(6'h06, 0, 1, 1, 1, 0, 3'd0, 3'd0, 1, 1),
          pv(6'h06, 0, 1, 1, 1, 0, 3'd0, 3'd0, 1, 1),
          pv(6'h00, 1, 1, 1, 1, 0, 3'd1, 3'd1, 1, 1),
          pv(6'h00, 1, 0, 1, 1, 0, 3'd0, 3'd0, 1, 1),
          pv(6'h00, 1, 1, 1, 1, 0, 3'd0, 3'd0, 0, 1),
          pv(6'h06, 0, 1, 1, 1, 0, 3'd0, 3'd0, 1, 1),
          pv(6'h00, 1, 1, 1, 1, 0, 3'd1, 3'd1, 1, 1)};
    do_reset();
    foreach (t[i]) begin
      step(t[i].v, t[i].v, t[i].v, t[i].bl, t[i].hs, t[i].vs, t[i].den, t[i].rs);
      vectors++;
      if ({obs0, obs1} !== {t[i].e0, t[i].e0, t[i].e0, t[i].ehs, t[i].evs,
                            t[i].e1, t[i].e1, t[i].e1, t[i].ehs, t[i].evs}) begin
        miscompares++;
        $display("FAIL reset_midline[%0d]: got %h/%h want c%0d/c%0d hs%0b vs%0b",
                 i, obs0, obs1, t[i].e0, t[i].e1, t[i].ehs, t[i].evs);
      end
    end
  endtask

  task automatic test_simultaneous_edges();
    vec_t t [5];
    t = '{pv(6'h06, 0, 1, 1, 1, 0, 3'd0, 3'd0, 1, 1),
          pv(6'h00, 1, 0, 0, 1, 0, 3'd0, 3'd0, 1, 1),
          pv(6'h00, 1, 1, 1, 1, 0, 3'd0, 3'd0, 0, 0),
          pv(6'h06, 0, 1, 1, 1, 0, 3'd0, 3'd0, 1, 1),
          pv(6'h00, 1, 1, 1, 1, 0, 3'd1, 3'd0, 1, 1)};
    do_reset();
    foreach (t[i]) begin
      step(t[i].v, t[i].v, t[i].v, t[i].bl, t[i].hs, t[i].vs, t[i].den, t[i].rs);
      vectors++;
      if ({obs0, obs1} !== {t[i].e0, t[i].e0, t[i].e0, t[i].ehs, t[i].evs,
                            t[i].e1, t[i].e1, t[i].e1, t[i].ehs, t[i].evs}) begin
        miscompares++;
        $display("FAIL simul_edges[%0d]: got %h/%h want c%0d/c%0d hs%0b vs%0b",
                 i, obs0, obs1, t[i].e0, t[i].e1, t[i].ehs, t[i].evs);
      end
    end
  endtask

  initial begin
    rst = 1'b1; pix_ce = 1'b0;
    r_in = '0; g_in = '0; b_in = '0;
    blank_in = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1; dither_en = 1'b0;
    do_reset();
    test_reset();
    test_truncation();
    test_spatial();
    test_saturation();
    test_temporal();
    test_blank();
    test_dither_toggle();
    test_reset_midline();
    test_simultaneous_edges();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_dither.md
# vga_dither

Ordered-dither output stage that sits between the monochrome/colour selection logic and the 3-bit-per-channel VGA DAC pins. It takes 6-bit R/G/B per pixel and quantises each channel to 3 bits with a 2x2 Bayer matrix, optionally alternated per frame, instead of dropping the low bits. Raster position is tracked from the sync signals it forwards, so it needs no coupling to the video timing generator. HSYNC/VSYNC are delayed to stay aligned with the pixel data.

## Interface
Parameters:
- SYNC_ACTIVE_LOW, default 1: when 1, HSYNC/VSYNC are active-low; the leading edge is 1→0.
- TEMPORAL, default 1: when 1, the Bayer column index is XORed with the frame parity.

Ports:
- clk_vga  in  1  pixel-domain clock (28.636 MHz). One clock; all logic on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- pix_ce  in  1  pixel strobe; input is sampled and the pipeline advances only when it is 1.
- r_in, g_in, b_in  in  6 each  pixel colour.
- blank_in  in  1  1 = outside the active area.
- hsync_in, vsync_in  in  1 each  raw sync signals from the video timing generator.
- dither_en  in  1  0 = plain truncation (value[5:3]).
- vga_r, vga_g, vga_b  out  3 each  quantised colour to the DAC pins.
- vga_hsync, vga_vsync  out  1 each  sync signals delayed to match the data.

## Operation
- Edge detect: previous-sample registers for hsync_in/vsync_in are updated on pix_ce. A leading edge is the transition into the active level.
- col_par: toggles on every pix_ce while blank_in=0. Cleared to 0 on an hsync leading edge.
- row_par: toggles on an hsync leading edge. Cleared to 0 on a vsync leading edge; clear wins over toggle.
- frame_par: toggles on a vsync leading edge. Held at 0 when TEMPORAL=0.
- Matrix index:
  - idx = {row_par, col_par ^ (TEMPORAL & frame_par)}.
  - Offsets: 00→0, 01→4, 10→6, 11→2.
- Per channel:
  - 7-bit sum s = {1'b0, v} + offset.
  - Saturate: s>63 → 63.
  - Output = sat[5:3].
  - When dither_en=0, offset is forced to 0.
- When blank is active, all colour outputs are 0 regardless of the input value.
- Sync signals pass through unmodified, delayed by the pipeline depth.

## Timing
- Two-stage pipeline, advancing only on pix_ce:
  - Stage 1 registers the colour inputs, blank, syncs and the selected offset. The offset uses the counter values before the current sample's update.
  - Stage 2 registers the add, saturate and slice.
- Latency is 2 pix_ce strobes from input to output, identical for colour and sync.
- Reset (synchronous, takes priority over pix_ce):
  - vga_r/g/b = 0.
  - vga_hsync/vga_vsync = inactive level (1 if SYNC_ACTIVE_LOW).
  - All parity counters = 0; edge-detect registers = inactive level.
- Reset asserted mid-line: outputs reach their reset values on the next clk_vga edge. The first valid pixel appears 2 strobes after reset is released.
- pix_ce=0: all state holds and outputs stay stable.
- hsync and vsync leading edges on the same strobe:
  - row_par is cleared (not toggled) and col_par is cleared.
  - frame_par toggles.
- dither_en changing mid-frame takes effect on the next sampled pixel. No glitch is allowed beyond the normal 2-strobe latency.

## Structure
- Shared package `vga_pkg`: the Bayer offset constants (4 × 3-bit), the colour width (6) and the DAC width (3). The existing monochrome stage uses the same package.
- One sub-module, `dither_channel`: 6-bit value plus 3-bit offset in, saturated 3-bit result out, purely combinational. It is instantiated three times.
- Counters, edge detection and pipeline registers live in the top module.

## Test plan
- Truncation: dither_en=0, r=6'h2F, steady strobes → vga_r=3'h5 exactly 2 strobes later; syncs aligned with the data.
- Spatial pattern: dither_en=1, TEMPORAL=0, all channels 6'h05 over a 2x2 area. Row 0 gives 0,1 (offsets 0,4); row 1 gives 1,0 (offsets 6,2).
- Saturation: value 6'h3F, offset 6 → output 3'h7 with no wrap. Value 6'h3A, offset 6 → 3'h7.
- Temporal: TEMPORAL=1, 6'h05 at (row 0, col 0) → 0 in frame 0 and 1 in frame 1.
- Blanking and reset:
  - blank_in=1 with colour 6'h3F → outputs 0.
  - rst pulse mid-line → outputs 0 and syncs inactive on the next edge; the pattern restarts at offset 0 on the following line.
- Simultaneous hsync/vsync leading edges → row_par=0, col_par=0, frame_par toggled. Checked via the first pixel of the next line.
